// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: functional-unit indices and the FU index width helper.
package pipeline_pkg;

  localparam int unsigned FU_MUL         = 0;
  localparam int unsigned FU_DIV         = 1;
  localparam int unsigned NUM_FU_DEFAULT = 2;
  localparam int unsigned FU_IW_DEFAULT  = 1;

  typedef logic [FU_IW_DEFAULT-1:0] fu_idx_t;

  // Width of an FU index; never narrower than one bit.
  function automatic int unsigned fu_iw(input int unsigned num_fu);
    return (num_fu > 1) ? $clog2(num_fu) : 1;
  endfunction

endpackage

// File: rtl/hazard_fu_tracker.sv
// Per-FU in-flight state: busy flag, destination register and a one-cycle kill pulse.
module hazard_fu_tracker #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_done,
  input  logic              i_issue,
  input  logic [REG_AW-1:0] i_issue_rd,
  input  logic              i_kill,
  output logic              o_busy,
  output logic [REG_AW-1:0] o_rd,
  output logic              o_kill
);

  logic              busy_q;
  logic [REG_AW-1:0] rd_q;
  logic              kill_q;

  // A new issue wins over a same-cycle completion; kill and issue never target the same FU.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_q <= 1'b0;
      rd_q   <= '0;
      kill_q <= 1'b0;
    end else begin
      kill_q <= i_kill;
      if (i_issue) begin
        busy_q <= 1'b1;
        rd_q   <= i_issue_rd;
      end else if (i_kill || i_done) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign o_busy = busy_q;
  assign o_rd   = rd_q;
  assign o_kill = kill_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard: per-register pending/owner table, stall generation, WAW kill,
// FU writeback gating and WB bypass match.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_FU   = NUM_FU_DEFAULT,
  localparam int unsigned REG_AW  = $clog2(NUM_REGS),
  localparam int unsigned FU_IW   = fu_iw(NUM_FU)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic              i_id_use_rs1,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic              i_id_use_rs2,
  input  logic [REG_AW-1:0] i_id_rd_addr,
  input  logic              i_id_wren,
  input  logic [NUM_FU-1:0] i_id_fu_en,
  input  logic              i_id_fire,
  input  logic [REG_AW-1:0] i_ex_rd_addr,
  input  logic              i_ex_load_instr,
  input  logic              i_wb_wren,
  input  logic [REG_AW-1:0] i_wb_rd_addr,
  input  logic [NUM_FU-1:0] i_fu_done,
  output logic              o_stall_from_ID,
  output logic              o_rs1_eq_rd_WB,
  output logic              o_rs2_eq_rd_WB,
  output logic [NUM_FU-1:0] o_fu_wb_allow,
  output logic [NUM_FU-1:0] o_fu_kill,
  output logic [NUM_FU-1:0] o_fu_busy
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [FU_IW-1:0]    owner_q [NUM_REGS];
  logic [FU_IW-1:0]    owner_d [NUM_REGS];

  logic [REG_AW-1:0]   fu_rd [NUM_FU];
  logic [NUM_FU-1:0]   issue_fu;
  logic [NUM_FU-1:0]   kill_req;
  logic [NUM_FU-1:0]   wb_allow;

  logic rs1_hit, rs2_hit;
  logic rs1_release, rs2_release;
  logic load_use, raw, structural;
  logic do_issue, fu_issue;

  assign rs1_hit  = i_id_use_rs1 && (i_id_rs1_addr != '0);
  assign rs2_hit  = i_id_use_rs2 && (i_id_rs2_addr != '0);
  assign do_issue = i_id_fire && i_id_wren && (i_id_rd_addr != '0);
  assign fu_issue = |i_id_fu_en;

  // A pending source is released early when its owning FU delivers it this very cycle.
  always_comb begin
    rs1_release = 1'b0;
    rs2_release = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (owner_q[i_id_rs1_addr] == FU_IW'(k) && i_fu_done[k] && fu_rd[k] == i_id_rs1_addr)
        rs1_release = 1'b1;
      if (owner_q[i_id_rs2_addr] == FU_IW'(k) && i_fu_done[k] && fu_rd[k] == i_id_rs2_addr)
        rs2_release = 1'b1;
    end
  end

  always_comb begin
    load_use   = i_ex_load_instr &&
                 ((rs1_hit && i_id_rs1_addr == i_ex_rd_addr) ||
                  (rs2_hit && i_id_rs2_addr == i_ex_rd_addr));
    raw        = (rs1_hit && pend_q[i_id_rs1_addr] && !rs1_release) ||
                 (rs2_hit && pend_q[i_id_rs2_addr] && !rs2_release);
    structural = |(i_id_fu_en & o_fu_busy & ~i_fu_done);
  end

  assign o_stall_from_ID = i_id_valid && (load_use || raw || structural);
  assign o_rs1_eq_rd_WB  = rs1_hit && i_wb_wren && (i_id_rs1_addr == i_wb_rd_addr);
  assign o_rs2_eq_rd_WB  = rs2_hit && i_wb_wren && (i_id_rs2_addr == i_wb_rd_addr);

  always_comb begin
    for (int k = 0; k < NUM_FU; k++) begin
      wb_allow[k] = i_fu_done[k] && pend_q[fu_rd[k]] && (owner_q[fu_rd[k]] == FU_IW'(k));
      issue_fu[k] = do_issue && i_id_fu_en[k];
      // WAW: a younger writer to the same rd supersedes FU k unless k finishes now.
      kill_req[k] = do_issue && pend_q[i_id_rd_addr] && (owner_q[i_id_rd_addr] == FU_IW'(k)) &&
                    !i_fu_done[k] && (!fu_issue || !i_id_fu_en[k]);
    end
  end

  assign o_fu_wb_allow = wb_allow;

  // Completion first, then issue, so a same-cycle issue on the same rd keeps it pending.
  always_comb begin
    pend_d  = pend_q;
    owner_d = owner_q;
    for (int k = 0; k < NUM_FU; k++) begin
      if (wb_allow[k]) pend_d[fu_rd[k]] = 1'b0;
    end
    if (do_issue) begin
      pend_d[i_id_rd_addr] = fu_issue;
      for (int k = 0; k < NUM_FU; k++) begin
        if (i_id_fu_en[k]) owner_d[i_id_rd_addr] = FU_IW'(k);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pend_q  <= '0;
      owner_q <= '{default: '0};
    end else begin
      pend_q  <= pend_d;
      owner_q <= owner_d;
    end
  end

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    hazard_fu_tracker #(
      .REG_AW (REG_AW)
    ) u_tracker (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_done     (i_fu_done[g]),
      .i_issue    (issue_fu[g]),
      .i_issue_rd (i_id_rd_addr),
      .i_kill     (kill_req[g]),
      .o_busy     (o_fu_busy[g]),
      .o_rd       (fu_rd[g]),
      .o_kill     (o_fu_kill[g])
    );
  end

  fire_while_stalled: assert property (@(posedge i_clk) disable iff (i_reset)
    !(i_id_fire && o_stall_from_ID));

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stalls, bypass, WAW kill and writeback gating.
module tb_hazard_scoreboard;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned NUM_FU   = 2;
  localparam int unsigned REG_AW   = 5;

  logic              i_clk = 1'b0;
  logic              i_reset;
  logic              i_id_valid;
  logic [REG_AW-1:0] i_id_rs1_addr;
  logic              i_id_use_rs1;
  logic [REG_AW-1:0] i_id_rs2_addr;
  logic              i_id_use_rs2;
  logic [REG_AW-1:0] i_id_rd_addr;
  logic              i_id_wren;
  logic [NUM_FU-1:0] i_id_fu_en;
  logic              i_id_fire;
  logic [REG_AW-1:0] i_ex_rd_addr;
  logic              i_ex_load_instr;
  logic              i_wb_wren;
  logic [REG_AW-1:0] i_wb_rd_addr;
  logic [NUM_FU-1:0] i_fu_done;
  logic              o_stall_from_ID;
  logic              o_rs1_eq_rd_WB;
  logic              o_rs2_eq_rd_WB;
  logic [NUM_FU-1:0] o_fu_wb_allow;
  logic [NUM_FU-1:0] o_fu_kill;
  logic [NUM_FU-1:0] o_fu_busy;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_FU   (NUM_FU)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_id_valid      (i_id_valid),
    .i_id_rs1_addr   (i_id_rs1_addr),
    .i_id_use_rs1    (i_id_use_rs1),
    .i_id_rs2_addr   (i_id_rs2_addr),
    .i_id_use_rs2    (i_id_use_rs2),
    .i_id_rd_addr    (i_id_rd_addr),
    .i_id_wren       (i_id_wren),
    .i_id_fu_en      (i_id_fu_en),
    .i_id_fire       (i_id_fire),
    .i_ex_rd_addr    (i_ex_rd_addr),
    .i_ex_load_instr (i_ex_load_instr),
    .i_wb_wren       (i_wb_wren),
    .i_wb_rd_addr    (i_wb_rd_addr),
    .i_fu_done       (i_fu_done),
    .o_stall_from_ID (o_stall_from_ID),
    .o_rs1_eq_rd_WB  (o_rs1_eq_rd_WB),
    .o_rs2_eq_rd_WB  (o_rs2_eq_rd_WB),
    .o_fu_wb_allow   (o_fu_wb_allow),
    .o_fu_kill       (o_fu_kill),
    .o_fu_busy       (o_fu_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    i_id_valid      = 1'b0;
    i_id_rs1_addr   = '0;
    i_id_use_rs1    = 1'b0;
    i_id_rs2_addr   = '0;
    i_id_use_rs2    = 1'b0;
    i_id_rd_addr    = '0;
    i_id_wren       = 1'b0;
    i_id_fu_en      = '0;
    i_id_fire       = 1'b0;
    i_ex_rd_addr    = '0;
    i_ex_load_instr = 1'b0;
    i_wb_wren       = 1'b0;
    i_wb_rd_addr    = '0;
    i_fu_done       = '0;
  endtask

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  // Present an issuing instruction, let it fire on the next edge, then idle the ID inputs.
  task automatic issue(input logic [REG_AW-1:0] rd, input logic [NUM_FU-1:0] fu_en);
    i_id_valid   = 1'b1;
    i_id_wren    = 1'b1;
    i_id_rd_addr = rd;
    i_id_fu_en   = fu_en;
    i_id_fire    = 1'b1;
    #1;
    chk("issue_no_stall", o_stall_from_ID, 1'b0);
    cyc();
    clr();
    #1;
  endtask

  task automatic read_rs1(input logic [REG_AW-1:0] rs);
    i_id_valid    = 1'b1;
    i_id_use_rs1  = 1'b1;
    i_id_rs1_addr = rs;
    #1;
  endtask

  initial begin
    clr();
    i_reset = 1'b1;
    #1;
    chk("reset_busy", o_fu_busy, 2'b00);
    chk("reset_kill", o_fu_kill, 2'b00);
    chk("reset_stall", o_stall_from_ID, 1'b0);
    cyc();
    i_reset = 1'b0;
    cyc();

    // 1: reset in the middle of a MUL clears the table asynchronously.
    issue(5'd5, 2'b01);
    chk("t1_mul_busy", o_fu_busy, 2'b01);
    i_reset = 1'b1;
    #1;
    chk("t1_busy_after_rst", o_fu_busy, 2'b00);
    chk("t1_kill_after_rst", o_fu_kill, 2'b00);
    read_rs1(5'd5);
    chk("t1_no_stall_x5", o_stall_from_ID, 1'b0);
    clr();
    cyc();
    i_reset = 1'b0;
    cyc();

    // 2: RAW on a pending MUL result, released the cycle the MUL completes.
    issue(5'd5, 2'b01);
    read_rs1(5'd5);
    chk("t2_raw_stall", o_stall_from_ID, 1'b1);
    cyc();
    chk("t2_raw_stall_hold", o_stall_from_ID, 1'b1);
    i_fu_done = 2'b01;
    i_id_wren = 1'b1;
    i_id_rd_addr = 5'd6;
    #1;
    chk("t2_release", o_stall_from_ID, 1'b0);
    chk("t2_wb_allow", o_fu_wb_allow, 2'b01);
    i_id_fire = 1'b1;
    cyc();
    clr();
    #1;
    chk("t2_mul_idle", o_fu_busy, 2'b00);
    read_rs1(5'd5);
    chk("t2_x5_clear", o_stall_from_ID, 1'b0);
    clr();
    cyc();

    // 3: load-use on rs2, x0 exempt, gone once the load leaves EX.
    i_id_valid      = 1'b1;
    i_id_use_rs2    = 1'b1;
    i_id_rs2_addr   = 5'd7;
    i_ex_load_instr = 1'b1;
    i_ex_rd_addr    = 5'd7;
    #1;
    chk("t3_load_use", o_stall_from_ID, 1'b1);
    i_id_rs2_addr = 5'd0;
    #1;
    chk("t3_rs2_x0", o_stall_from_ID, 1'b0);
    i_id_rs2_addr   = 5'd7;
    i_ex_load_instr = 1'b0;
    #1;
    chk("t3_load_gone", o_stall_from_ID, 1'b0);
    clr();
    cyc();

    // 4: WAW against an in-flight DIV kills the DIV and blocks its writeback.
    issue(5'd9, 2'b10);
    chk("t4_div_busy", o_fu_busy, 2'b10);
    issue(5'd9, 2'b00);
    chk("t4_kill_pulse", o_fu_kill, 2'b10);
    chk("t4_div_freed", o_fu_busy, 2'b00);
    read_rs1(5'd9);
    chk("t4_x9_not_pend", o_stall_from_ID, 1'b0);
    clr();
    cyc();
    chk("t4_kill_cleared", o_fu_kill, 2'b00);
    i_fu_done = 2'b10;
    #1;
    chk("t4_wb_blocked", o_fu_wb_allow, 2'b00);
    clr();
    cyc();

    // 5: busy MUL stalls a second MUL until done; same-cycle done+issue on x3 keeps it pending.
    issue(5'd3, 2'b01);
    i_id_valid   = 1'b1;
    i_id_wren    = 1'b1;
    i_id_rd_addr = 5'd3;
    i_id_fu_en   = 2'b01;
    #1;
    chk("t5_struct_stall", o_stall_from_ID, 1'b1);
    i_fu_done = 2'b01;
    #1;
    chk("t5_struct_release", o_stall_from_ID, 1'b0);
    chk("t5_wb_allow", o_fu_wb_allow, 2'b01);
    i_id_fire = 1'b1;
    cyc();
    clr();
    #1;
    chk("t5_mul_busy_again", o_fu_busy, 2'b01);
    chk("t5_no_kill", o_fu_kill, 2'b00);
    read_rs1(5'd3);
    chk("t5_x3_still_pend", o_stall_from_ID, 1'b1);
    i_fu_done = 2'b01;
    #1;
    chk("t5_x3_owner_mul", o_fu_wb_allow, 2'b01);
    chk("t5_x3_release", o_stall_from_ID, 1'b0);
    cyc();
    i_fu_done = 2'b00;
    #1;
    chk("t5_x3_done", o_stall_from_ID, 1'b0);
    clr();
    cyc();

    // 6: WB bypass match on both sources, independent of ID valid.
    i_id_use_rs1  = 1'b1;
    i_id_use_rs2  = 1'b1;
    i_id_rs1_addr = 5'd4;
    i_id_rs2_addr = 5'd4;
    i_wb_wren     = 1'b1;
    i_wb_rd_addr  = 5'd4;
    #1;
    chk("t6_rs1_bypass", o_rs1_eq_rd_WB, 1'b1);
    chk("t6_rs2_bypass", o_rs2_eq_rd_WB, 1'b1);
    i_wb_wren = 1'b0;
    #1;
    chk("t6_rs1_no_wren", o_rs1_eq_rd_WB, 1'b0);
    chk("t6_rs2_no_wren", o_rs2_eq_rd_WB, 1'b0);
    clr();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
